// File: rtl/cmd3_io_pkg.sv
// Shared definitions for the front-panel input conditioner.
// Holds the default stable time and the per-channel state view used by bench monitors.
package cmd3_io_pkg;

    localparam int unsigned DEBOUNCE_STABLE_DEF = 16;

    typedef struct packed {
        logic s1;
        logic s2;
        logic q;
    } deb_state_t;

endpackage

// File: rtl/debounce_ch.sv
// Single-channel synchroniser + debouncer with registered level and edge strobes.
// Optional sticky rise flag when DEBOUNCE_LATCH_EN is defined.
module debounce_ch
    import cmd3_io_pkg::*;
#(
    parameter int unsigned STABLE = DEBOUNCE_STABLE_DEF
) (
    input  logic clk,
    input  logic clrn,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
`ifdef DEBOUNCE_LATCH_EN
    ,
    input  logic ack,
    output logic flag
`endif
);

    localparam int unsigned     CNT_W  = $clog2(STABLE);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Any sample agreeing with the output restarts the stable-time window.
    always_comb begin
        cnt_d  = '0;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q != q_q) begin
            if (cnt_q == CntMax) begin
                q_d    = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_in;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_LATCH_EN
    logic flag_q;

    // Set has priority so a rise is never lost to a coincident ack.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            flag_q <= 1'b0;
        end else if (rise_d) begin
            flag_q <= 1'b1;
        end else if (ack) begin
            flag_q <= 1'b0;
        end
    end

    assign flag = flag_q;
`endif

endmodule

// File: rtl/input_debounce_sync.sv
// W-channel input conditioner feeding the DFF1 bank: sync, debounce, edge strobes.
// Define DEBOUNCE_LATCH_EN to add per-channel ack inputs and sticky rise flags.
module input_debounce_sync
    import cmd3_io_pkg::*;
#(
    parameter int unsigned W      = 1,
    parameter int unsigned STABLE = DEBOUNCE_STABLE_DEF
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
`ifdef DEBOUNCE_LATCH_EN
    ,
    input  logic [W-1:0] ack,
    output logic [W-1:0] flag
`endif
);

    for (genvar i = 0; i < W; i++) begin : g_ch
        debounce_ch #(
            .STABLE(STABLE)
        ) u_ch (
            .clk (clk),
            .clrn(clrn),
            .d_in(d_in[i]),
            .q   (q[i]),
            .rise(rise[i]),
            .fall(fall[i])
`ifdef DEBOUNCE_LATCH_EN
            ,
            .ack (ack[i]),
            .flag(flag[i])
`endif
        );
    end

endmodule
